mem_line_reader: RTL and testbench

- Downstream consumer of the image/weight memory.
- Walks a contiguous address window via the memory's combinational read port (rd_adr -> rd_data, same-cycle) and streams the words out through a valid/ready interface, buffered by a small prefetch FIFO.
- Feeds the processing datapath one 32-bit word per accepted handshake.
- Decouples memory address sequencing from consumer stalls.

---
 rtl/mem_line_reader_pkg.sv | 15 +
 rtl/mem_line_reader_if.sv | 49 ++++
 rtl/mem_line_reader_fifo.sv | 63 ++++++
 rtl/mem_line_reader.sv | 129 ++++++++++++
 tb/tb_mem_line_reader.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_line_reader_pkg.sv
// Shared definitions for the memory line reader: the address-sequencer state
// encoding and the default image window shared with the memory layout.
package mem_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Default image window inside the image/weight memory.
    localparam int DEFAULT_START_ADR = 16;
    localparam int DEFAULT_NUM_WORDS = 64;

endpackage

// File: rtl/mem_line_reader_if.sv
// Bundle of the reader's control, memory read-port and output stream signals.
// Optional macro MEM_LINE_READER_STRIDE_EN adds the per-run stride input.
interface mem_line_reader_if #(
    parameter int ADR_WIDTH  = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic [ADR_WIDTH-1:0]  rd_adr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
`ifdef MEM_LINE_READER_STRIDE_EN
    logic [ADR_WIDTH-1:0]  stride;
`endif

    // Reader side.
    modport master (
        input  start,
        input  rd_data,
        input  out_ready,
`ifdef MEM_LINE_READER_STRIDE_EN
        input  stride,
`endif
        output busy,
        output done,
        output rd_adr,
        output out_data,
        output out_valid
    );

    // Memory / consumer / controller side.
    modport slave (
        output start,
        output rd_data,
        output out_ready,
`ifdef MEM_LINE_READER_STRIDE_EN
        output stride,
`endif
        input  busy,
        input  done,
        input  rd_adr,
        input  out_data,
        input  out_valid
    );

endinterface

// File: rtl/mem_line_reader_fifo.sv
// sync_fifo: small synchronous prefetch FIFO. Head word is read straight out
// of registered storage, so pop_data never depends on push_data in the same
// cycle. Push and pop may coincide, including when full.
module sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  empty
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] store_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  do_push;
    logic                  do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == DEPTH_CNT);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = store_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping.
    // NOTE: registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Word storage; a simultaneous push into the slot being popped is safe
    // because the pop reads the old contents this cycle.
    // NOTE: storage is reset because the head entry drives out_data directly and must read zero after reset; a large RAM would normally stay unreset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) store_q[i] <= '0;
        end else if (do_push) begin
            store_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/mem_line_reader.sv
// mem_line_reader: walks NUM_WORDS addresses from START_ADR through the
// memory's combinational read port and streams the words out via a prefetch
// FIFO. Define MEM_LINE_READER_STRIDE_EN to take the address increment from
// the stride input (sampled on start); otherwise the increment is 1.
module mem_line_reader
    import mem_reader_pkg::*;
#(
    parameter int ADR_WIDTH  = 8,
    parameter int DATA_WIDTH = 32,
    parameter int START_ADR  = DEFAULT_START_ADR,
    parameter int NUM_WORDS  = DEFAULT_NUM_WORDS,
    parameter int FIFO_DEPTH = 4
) (
    input logic               clk,
    input logic               rst,
    mem_line_reader_if.master bus
);
    localparam int CNT_W = ADR_WIDTH + 1;
    localparam logic [CNT_W-1:0]     LAST_IDX  = CNT_W'(NUM_WORDS - 1);
    localparam logic [ADR_WIDTH-1:0] START_VAL = ADR_WIDTH'(START_ADR);

    state_t               state_q, state_d;
    logic [ADR_WIDTH-1:0] adr_q, adr_d;
    logic [ADR_WIDTH-1:0] incr;
    logic [CNT_W-1:0]     fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0]     accept_cnt_q, accept_cnt_d;
    logic                 done_q, done_d;
    logic                 push;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;

`ifdef MEM_LINE_READER_STRIDE_EN
    logic [ADR_WIDTH-1:0] stride_q, stride_d;
    assign incr = stride_q;
`else
    assign incr = ADR_WIDTH'(1);
`endif

    assign pop           = !fifo_empty && bus.out_ready;
    assign bus.out_valid = !fifo_empty;
    assign bus.rd_adr    = adr_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (bus.rd_data),
        .pop       (pop),
        .pop_data  (bus.out_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Next-state logic: address sequencing, word counters and the done pulse.
    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        adr_d        = adr_q;
        fetch_cnt_d  = fetch_cnt_q;
        accept_cnt_d = accept_cnt_q;
        done_d       = 1'b0;
        push         = 1'b0;
`ifdef MEM_LINE_READER_STRIDE_EN
        stride_d     = stride_q;
`endif

        if (pop) accept_cnt_d = accept_cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d      = FETCH;
                    adr_d        = START_VAL;
                    fetch_cnt_d  = '0;
                    accept_cnt_d = '0;
`ifdef MEM_LINE_READER_STRIDE_EN
                    stride_d     = bus.stride;
`endif
                end
            end
            FETCH: begin
                // A slot frees up this cycle if the consumer pops, even when full.
                push = !fifo_full || pop;
                if (push) begin
                    adr_d       = adr_q + incr;
                    fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
                    if (fetch_cnt_q == LAST_IDX) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && (accept_cnt_q == LAST_IDX)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, address, counter and done registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            adr_q        <= '0;
            fetch_cnt_q  <= '0;
            accept_cnt_q <= '0;
            done_q       <= 1'b0;
`ifdef MEM_LINE_READER_STRIDE_EN
            stride_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            adr_q        <= adr_d;
            fetch_cnt_q  <= fetch_cnt_d;
            accept_cnt_q <= accept_cnt_d;
            done_q       <= done_d;
`ifdef MEM_LINE_READER_STRIDE_EN
            stride_q     <= stride_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_line_reader.sv
// Testbench for mem_line_reader. Two instances: the default window (16, 64)
// and a wrapping window (250, 10). Expected words come from a reference model
// that computes each run's address list directly; a monitor pops and compares.
`timescale 1ns/1ps
module tb_mem_line_reader;
    import mem_reader_pkg::*;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NI = 2;

    typedef struct {
        logic [DW-1:0] data;
        bit            last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [DW-1:0] mem [256];
    logic          start_s [NI];
    logic          ready_s [NI];
`ifdef MEM_LINE_READER_STRIDE_EN
    logic [AW-1:0] stride_s [NI];
`endif
    logic [AW-1:0] adr_o   [NI];
    logic [DW-1:0] data_o  [NI];
    logic          valid_o [NI];
    logic          busy_o  [NI];
    logic          done_o  [NI];

    exp_t exp_q [NI][$];
    bit   done_due [NI];
    int   acc_cnt [NI];
    int   ready_mode [NI];   // 0: always ready, 1: random 50%, 2: held low
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   done_cyc;
    int   c1;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int SA = (g == 0) ? DEFAULT_START_ADR : 250;
        localparam int NW = (g == 0) ? DEFAULT_NUM_WORDS : 10;

        mem_line_reader_if #(.ADR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

        assign bus.start     = start_s[g];
        assign bus.out_ready = ready_s[g];
        assign bus.rd_data   = mem[bus.rd_adr];
`ifdef MEM_LINE_READER_STRIDE_EN
        assign bus.stride    = stride_s[g];
`endif
        assign adr_o[g]   = bus.rd_adr;
        assign data_o[g]  = bus.out_data;
        assign valid_o[g] = bus.out_valid;
        assign busy_o[g]  = bus.busy;
        assign done_o[g]  = bus.done;

        mem_line_reader #(
            .ADR_WIDTH  (AW),
            .DATA_WIDTH (DW),
            .START_ADR  (SA),
            .NUM_WORDS  (NW),
            .FIFO_DEPTH (4)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    function automatic int sa_of(input int g);
        return (g == 0) ? DEFAULT_START_ADR : 250;
    endfunction

    function automatic int nw_of(input int g);
        return (g == 0) ? DEFAULT_NUM_WORDS : 10;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Reference model: word i of a run comes from (start + i*stride) mod 256.
    task automatic load_expect(input int g, input int stride);
        for (int i = 0; i < nw_of(g); i++) begin
            exp_t e;
            int   a;
            a      = (sa_of(g) + i * stride) % 256;
            e.data = mem[a];
            e.last = (i == nw_of(g) - 1);
            exp_q[g].push_back(e);
        end
    endtask

    // Called at posedge+1; start is held for exactly one cycle.
    task automatic do_start(input int g, input int stride);
        load_expect(g, stride);
        acc_cnt[g] = 0;
`ifdef MEM_LINE_READER_STRIDE_EN
        stride_s[g] = AW'(stride);
`endif
        start_s[g] = 1'b1;
        @(posedge clk); #1;
        start_s[g] = 1'b0;
    endtask

    // Waits (bounded) for done; returns at posedge+1 in the done cycle.
    task automatic finish_run(input int g, input int stride, output int at_cyc);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 4000 && !seen; n++) begin
            @(posedge clk); #1;
            seen = done_o[g];
        end
        at_cyc = cyc;
        check($sformatf("done_seen[%0d]", g), 64'(seen), 64'd1);
        if (!seen) exp_q[g].delete();
        check($sformatf("accepted[%0d]", g), 64'(acc_cnt[g]), 64'(nw_of(g)));
        check($sformatf("leftover[%0d]", g), 64'(exp_q[g].size()), 64'd0);
        check($sformatf("end_adr[%0d]", g), 64'(adr_o[g]), 64'((sa_of(g) + nw_of(g) * stride) % 256));
    endtask

    // Consumer ready generator.
    initial begin
        forever begin
            @(posedge clk); #1;
            for (int g = 0; g < NI; g++) begin
                case (ready_mode[g])
                    0:       ready_s[g] = 1'b1;
                    1:       ready_s[g] = 1'($urandom_range(0, 1));
                    default: ready_s[g] = 1'b0;
                endcase
            end
        end
    end

    // Monitor: handshakes that will complete at the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            for (int g = 0; g < NI; g++) begin
                if (done_o[g] || done_due[g]) begin
                    check($sformatf("done_pulse[%0d]", g), 64'(done_o[g]), 64'(done_due[g]));
                    if (done_due[g]) check($sformatf("busy_at_done[%0d]", g), 64'(busy_o[g]), 64'd0);
                end
                done_due[g] = 1'b0;
                if (valid_o[g] && ready_s[g]) begin
                    if (exp_q[g].size() == 0) begin
                        check($sformatf("unexpected_word[%0d]", g), 64'(data_o[g]), 64'hDEAD);
                    end else begin
                        exp_t e;
                        e = exp_q[g].pop_front();
                        check($sformatf("data[%0d]#%0d", g, acc_cnt[g]), 64'(data_o[g]), 64'(e.data));
                        done_due[g] = e.last;
                        acc_cnt[g]++;
                    end
                end
            end
        end
    end

    initial begin
        bit reached;
        rst = 1'b1;
        for (int g = 0; g < NI; g++) begin
            start_s[g]    = 1'b0;
            ready_s[g]    = 1'b1;
            ready_mode[g] = 0;
            done_due[g]   = 1'b0;
            acc_cnt[g]    = 0;
`ifdef MEM_LINE_READER_STRIDE_EN
            stride_s[g]   = 8'd1;
`endif
        end
        for (int i = 0; i < 256; i++) mem[i] = DW'(i);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < NI; g++) begin
            check($sformatf("rst_adr[%0d]", g), 64'(adr_o[g]), 64'd0);
            check($sformatf("rst_valid[%0d]", g), 64'(valid_o[g]), 64'd0);
            check($sformatf("rst_busy[%0d]", g), 64'(busy_o[g]), 64'd0);
            check($sformatf("rst_done[%0d]", g), 64'(done_o[g]), 64'd0);
            check($sformatf("rst_data[%0d]", g), 64'(data_o[g]), 64'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Run 1: full-rate stream, exact latency and done timing.
        do_start(0, 1);
        c1 = cyc;
        check("fetch_busy", 64'(busy_o[0]), 64'd1);
        check("fetch_valid_low", 64'(valid_o[0]), 64'd0);
        @(posedge clk); #1;
        check("first_valid", 64'(valid_o[0]), 64'd1);
        check("first_data", 64'(data_o[0]), 64'h10);
        finish_run(0, 1, done_cyc);
        check("done_cycle", 64'(done_cyc - c1), 64'd65);

        // Run 2: started in the done cycle; consumer stalls for 10 cycles.
        ready_mode[0] = 2;
        do_start(0, 1);
        repeat (10) @(posedge clk);
        #1;
        check("stall_adr", 64'(adr_o[0]), 64'h14);
        check("stall_valid", 64'(valid_o[0]), 64'd1);
        check("stall_head", 64'(data_o[0]), 64'h10);
        check("stall_accepted", 64'(acc_cnt[0]), 64'd0);
        ready_mode[0] = 0;
        finish_run(0, 1, done_cyc);

        // Run 3: random memory contents, random ready, ignored mid-run start.
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        ready_mode[0] = 1;
        do_start(0, 1);
        repeat (30) @(posedge clk);
        #1;
        check("busy_midrun", 64'(busy_o[0]), 64'd1);
`ifdef MEM_LINE_READER_STRIDE_EN
        stride_s[0] = 8'd5;
`endif
        start_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        finish_run(0, 1, done_cyc);
        for (int i = 0; i < 256; i++) mem[i] = DW'(i);
        @(posedge clk); #1;
        check("idle_after_done", 64'(busy_o[0]), 64'd0);

        // Run 4: reset after 20 accepted words, then a fresh run.
        ready_mode[0] = 0;
        do_start(0, 1);
        reached = 1'b0;
        for (int n = 0; n < 500 && !reached; n++) begin
            @(posedge clk); #1;
            reached = (acc_cnt[0] >= 20);
        end
        check("reach_20", 64'(reached), 64'd1);
        rst = 1'b1;
        #1;
        check("midrst_adr", 64'(adr_o[0]), 64'd0);
        check("midrst_valid", 64'(valid_o[0]), 64'd0);
        check("midrst_busy", 64'(busy_o[0]), 64'd0);
        check("midrst_done", 64'(done_o[0]), 64'd0);
        check("midrst_data", 64'(data_o[0]), 64'd0);
        exp_q[0].delete();
        done_due[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("postrst_busy", 64'(busy_o[0]), 64'd0);
        check("postrst_valid", 64'(valid_o[0]), 64'd0);
        ready_mode[0] = 1;
        do_start(0, 1);
        finish_run(0, 1, done_cyc);

        // Run 5: address window wrapping past 255.
        @(posedge clk); #1;
        ready_mode[1] = 1;
        do_start(1, 1);
        finish_run(1, 1, done_cyc);

`ifdef MEM_LINE_READER_STRIDE_EN
        // Stride runs: stride 2 on both windows, stride 0 re-reads the start word.
        do_start(1, 2);
        stride_s[1] = 8'd7;
        finish_run(1, 2, done_cyc);
        do_start(1, 0);
        finish_run(1, 0, done_cyc);
        ready_mode[0] = 0;
        do_start(0, 2);
        finish_run(0, 2, done_cyc);
`endif

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
